// File: rtl/word_generator.sv
// rtl/word_generator.sv - generates numbered message words on a valid/ready stream after a start pulse
module word_generator #(
    parameter int WORD_COUNTER_SIZE = 8,
    parameter int WORD_SIZE         = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WORD_COUNTER_SIZE-1:0] msg_words_in,
    input  logic                         msg_start,
    output logic [WORD_SIZE-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         busy,
    output logic [WORD_COUNTER_SIZE-1:0] words_sent,
    output logic                         start_overrun
);

    localparam logic [WORD_COUNTER_SIZE-1:0] CNT_ONE = 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [15:0]                  msg_id;
    logic [15:0]                  msg_id_next;
    logic [WORD_COUNTER_SIZE-1:0] msg_len;
    logic [WORD_COUNTER_SIZE-1:0] word_idx;
    logic                         accept;
    logic                         handshake;
    logic                         last_word;

    assign last_word = (word_idx == msg_len - CNT_ONE);

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        handshake   = 1'b0;
        msg_id_next = msg_id;
        case (state)
            IDLE: begin
                // a zero-length start is silently ignored
                if (msg_start && (msg_words_in != '0)) begin
                    accept     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    if (last_word) begin
                        state_next  = IDLE;
                        msg_id_next = msg_id + 16'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // msg_id is rewritten every cycle so it always tracks msg_id_next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            msg_id        <= '0;
            msg_len       <= '0;
            word_idx      <= '0;
            words_sent    <= '0;
            start_overrun <= 1'b0;
        end else begin
            state         <= state_next;
            msg_id        <= msg_id_next;
            start_overrun <= msg_start && (state == SEND);
            if (accept) begin
                msg_len    <= msg_words_in;
                word_idx   <= '0;
                words_sent <= '0;
            end else if (handshake) begin
                word_idx   <= word_idx + CNT_ONE;
                words_sent <= words_sent + CNT_ONE;
            end
        end
    end

    assign busy      = (state == SEND);
    assign out_valid = busy;
    assign out_sop   = busy && (word_idx == '0);
    assign out_eop   = busy && last_word;

    always_comb begin
        out_data = '0;
        if (busy) begin
            out_data[WORD_COUNTER_SIZE-1:0]                  = word_idx;
            out_data[WORD_COUNTER_SIZE+15:WORD_COUNTER_SIZE] = msg_id;
        end
    end

endmodule

// File: doc/word_generator.md
WORD_GENERATOR -- requirements
Module: word_generator

Interface
REQ-001 Parameter WORD_COUNTER_SIZE, default 8, sets the width of the message word count and word index.
REQ-002 Parameter WORD_SIZE, default 32, sets the width of each generated data word; SHALL be >= 16 + WORD_COUNTER_SIZE.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge clocked.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 msg_words_in  input  WORD_COUNTER_SIZE  number of words to generate; sampled only on an accepted start.
REQ-006 msg_start  input  1  single-cycle start pulse from the register controller.
REQ-007 out_data  output  WORD_SIZE  generated word.
REQ-008 out_valid  output  1  out_data, out_sop and out_eop are valid.
REQ-009 out_ready  input  1  downstream accepts the word; a handshake is out_valid && out_ready in the same cycle.
REQ-010 out_sop  output  1  first word of a message.
REQ-011 out_eop  output  1  last word of a message.
REQ-012 busy  output  1  high while a message is in progress.
REQ-013 words_sent  output  WORD_COUNTER_SIZE  count of words handshaken in the current or last message.
REQ-014 start_overrun  output  1  single-cycle pulse when a msg_start is dropped.

Function
REQ-015 The FSM SHALL have two states: IDLE and SEND.
REQ-016 In IDLE, msg_start with msg_words_in != 0 SHALL be accepted: latch the length, clear the word index and words_sent, and enter SEND on the next edge.
REQ-017 In IDLE, msg_start with msg_words_in == 0 SHALL be ignored: no state change, no output activity, no start_overrun pulse, msg_id unchanged.
REQ-018 out_valid SHALL rise in the cycle after the accepting start edge, i.e. one-cycle start-to-first-word latency.
REQ-019 In SEND, out_valid SHALL be 1 continuously until the final handshake; it SHALL NOT drop between words.
REQ-020 While out_valid && !out_ready, out_data, out_sop and out_eop SHALL hold stable.
REQ-021 out_data SHALL be {zeros, msg_id[15:0], word_idx}: msg_id in bits [WORD_COUNTER_SIZE+15:WORD_COUNTER_SIZE], word_idx in the low WORD_COUNTER_SIZE bits, and remaining upper bits 0.
REQ-022 word_idx SHALL start at 0 and increment by 1 on each handshake.
REQ-023 out_sop SHALL be 1 only when word_idx == 0.
REQ-024 out_eop SHALL be 1 only when word_idx == latched length - 1.
REQ-025 For a length of 1, out_sop and out_eop SHALL both be 1 on the single word.
REQ-026 Each handshake SHALL increment words_sent by 1; words_sent SHALL hold its value after the message until the next accepted start.
REQ-027 On the handshake of the eop word, the FSM SHALL return to IDLE: out_valid = 0 and busy = 0 from the next cycle.
REQ-028 On the same eop handshake, msg_id SHALL increment modulo 2^16 (16'hFFFF wraps to 0).
REQ-029 busy SHALL be 1 exactly while the FSM is in SEND.
REQ-030 msg_start while in SEND SHALL be ignored and SHALL pulse start_overrun for one cycle; this includes a start coinciding with the eop handshake.
REQ-031 A start_overrun pulse SHALL NOT change the latched length, the word index or the in-flight message.
REQ-032 Maximum length SHALL be 2^WORD_COUNTER_SIZE - 1 words (255 at default); the word index SHALL never wrap within a message.
REQ-033 out_ready SHALL have no effect while out_valid == 0.

Reset
REQ-034 While rst is 1, the FSM SHALL be IDLE and all outputs 0: out_valid, out_sop, out_eop, busy, words_sent, start_overrun and out_data.
REQ-035 While rst is 1, msg_id and the latched length SHALL be 0.
REQ-036 rst asserted mid-message SHALL abort the message immediately; no further words SHALL be emitted after deassertion until a new accepted start.

Verification
REQ-037 Test 1: rst release, msg_words_in=3, start, out_ready=1 -> data 0x00000000 (sop), 0x00000001, 0x00000002 (eop) on consecutive cycles starting 1 cycle after start; words_sent=3; busy falls after the eop handshake.
REQ-038 Test 2: second message of length 1 after Test 1 -> single word 0x00000100 with sop=eop=1; msg_id becomes 2.
REQ-039 Test 3: length 4 with out_ready toggling randomly -> all four words delivered in order, data stable during stalls, out_valid never drops mid-message.
REQ-040 Test 4: msg_start during SEND, including on the eop handshake cycle -> one start_overrun pulse per dropped start and the in-flight message unaffected.
REQ-041 Test 5: msg_words_in=0 with start -> no out_valid, busy=0, msg_id and words_sent unchanged; length 255 -> 255 words, last word index 0xFE with eop.
REQ-042 Test 6: rst asserted after the second word of a 5-word message -> outputs 0 asynchronously, no words after release, msg_id=0; force msg_id to 0xFFFF, complete a message -> msg_id=0.
